// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial N-bit adder, LSB-first, one bit per clock with registered carry
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sum_bit
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           s, c_nx;
  assign s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nx = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  // load on accepted start, then consume one operand bit per enabled edge until the MSB is summed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      sum_bit <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          a_sr  <= a_in;
          b_sr  <= b_in;
          carry <= 1'b0;
          cnt   <= '0;
          sum   <= '0;
          cout  <= 1'b0;
          busy  <= 1'b1;
        end
      end else begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        carry   <= c_nx;
        sum     <= {s, sum[WIDTH-1:1]};
        sum_bit <= s;
        cnt     <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cout  <= c_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table plus scoreboard check of the serial adder controller
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n, ena, start;
  logic [W-1:0] a_in, b_in, sum;
  logic busy, done, cout, sum_bit;
  int total = 0;
  int bad = 0;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] s; logic c;} vec_t;
  vec_t vecs[8];
  logic [W:0] sb[$];
  logic done_q;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .sum_bit(sum_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // completion monitor: each rising done must match the oldest outstanding expected result
  always @(negedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else begin
      if (done && !done_q) begin
        if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          logic [W:0] e;
          e = sb.pop_front();
          chk("sb_sum", 32'(sum), 32'(e[W-1:0]));
          chk("sb_cout", 32'(cout), 32'(e[W]));
        end
      end
      done_q <= done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s, input logic c);
    a_in = a;
    b_in = b;
    start = 1'b1;
    sb.push_back({c, s});
    step();
    start = 1'b0;
    a_in = ~a;
    b_in = a ^ b;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_done", 32'(done), 32'd0);
    chk("acc_sum_clr", 32'(sum), 32'd0);
    chk("acc_cout_clr", 32'(cout), 32'd0);
    for (int k = 1; k <= W; k++) begin
      step();
      chk("sum_bit", 32'(sum_bit), 32'(s[k-1]));
      chk("run_busy", 32'(busy), 32'(k < W));
      chk("run_done", 32'(done), 32'(k == W));
    end
    chk("op_sum", 32'(sum), 32'(s));
    chk("op_cout", 32'(cout), 32'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_sum_bit", 32'(sum_bit), 32'd0);
    rst_n = 1'b1;
    step();
    // back-to-back: each op starts on the cycle the previous done is high
    for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
    step();
    chk("done_fall", 32'(done), 32'd0);
    chk("sum_hold", 32'(sum), 32'h80);
    // start while busy is ignored
    a_in = 8'h10;
    b_in = 8'h20;
    start = 1'b1;
    sb.push_back({1'b0, 8'h30});
    step();
    start = 1'b0;
    step();
    step();
    a_in = 8'hFF;
    b_in = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    chk("ign_latency", 32'(n + 3), 32'd8);
    chk("ign_sum", 32'(sum), 32'h30);
    step();
    chk("ign_single_done", 32'(done), 32'd0);
    chk("ign_idle", 32'(busy), 32'd0);
    // ena stall mid-run
    a_in = 8'hAA;
    b_in = 8'h55;
    start = 1'b1;
    sb.push_back({1'b0, 8'hFF});
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("stall_sum", 32'(sum), 32'hE0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_sum_bit", 32'(sum_bit), 32'd1);
    ena = 1'b1;
    wait_done(n);
    chk("stall_latency", 32'(n + 6), 32'd11);
    ena = 1'b0;
    step();
    step();
    chk("stall_done_hold", 32'(done), 32'd1);
    ena = 1'b1;
    step();
    chk("stall_done_fall", 32'(done), 32'd0);
    // reset mid-run aborts with no done
    a_in = 8'h80;
    b_in = 8'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("abort_no_done", 32'(done), 32'd0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1);
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller. It sits directly upstream of the half-adder output stage inside tt_um_HA and replaces the single-bit combinational add with a multi-bit operation. Operands are loaded in parallel and summed LSB-first, one bit per clock, through a half-adder pair plus a registered carry. The controller then presents the parallel sum, the carry-out and a completion pulse to the uo_out mapping.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..16.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
start  input  1  request to load operands and begin an add
a_in  input  WIDTH  operand A, sampled only on an accepted start
b_in  input  WIDTH  operand B, sampled only on an accepted start
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse, sum/cout valid
sum  output  WIDTH  result register
cout  output  1  final carry-out
sum_bit  output  1  serial sum bit produced on the current RUN cycle (debug/observe)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, sum_bit=0.
  - Internal operand shift registers, carry flop and bit counter are cleared.
  - Release is synchronous to clk, with no extra cycles needed before start is accepted.
- ena=0: no register changes at all, including start acceptance, counter and shifts. Outputs hold. done, if high, stays high until the next ena=1 edge.
- State machine:
  - IDLE -> RUN on an edge with ena=1 and start=1.
  - RUN -> IDLE after the edge that processes bit WIDTH-1.
  - There is no separate DONE state; done is a registered flag.
- Start acceptance (IDLE, ena=1, start=1):
  - Load A_sr=a_in, B_sr=b_in, carry=0, cnt=0.
  - Clear sum and cout; busy=1 from this edge.
- RUN, each edge with ena=1:
  - s = A_sr[0] ^ B_sr[0] ^ carry.
  - carry <= (A_sr[0]&B_sr[0]) | (carry&(A_sr[0]^B_sr[0])).
  - A_sr, B_sr shift right, filling with 0.
  - sum shifts right with s entering at bit WIDTH-1.
  - sum_bit <= s; cnt increments.
- Completion, on the edge where cnt==WIDTH-1:
  - State goes to IDLE; busy <= 0; done <= 1.
  - cout <= the carry computed on that edge.
  - After this edge sum holds (a_in + b_in) mod 2^WIDTH and cout holds the carry.
- Latency: start accepted at edge 0; bits processed on edges 1..WIDTH; done high for exactly the cycle after edge WIDTH (with ena held 1). done deasserts on the next ena=1 edge.
- sum and cout hold their values until the next accepted start.
- start while busy=1 is ignored, with no effect on the operation in progress.
- start on the cycle done=1 (state already IDLE) is accepted: back-to-back ops, one idle-free gap.
- Reset asserted mid-RUN aborts immediately; no done pulse is generated for the aborted op.
- a_in/b_in changes after acceptance have no effect.
- Parent mapping (in tt_um_HA): uo_out[0]=sum_bit, uo_out[1]=cout, uo_out[2]=done, uo_out[3]=busy. This spec does not cover that mapping.

Test Plan:
- Basic add: reset, WIDTH=8, a_in=8'h35, b_in=8'h4A, pulse start -> busy high for 8 cycles, done pulses one cycle after 8th RUN edge, sum=8'h7F, cout=0.
- Full carry ripple: a_in=8'hFF, b_in=8'h01 -> sum=8'h00, cout=1, sum_bit=0 on all 8 RUN cycles, done at exactly edge 8 after start.
- Ignored start: start op 8'h10+8'h20, re-pulse start with a_in=8'hFF, b_in=8'hFF at RUN cycle 3 -> sum=8'h30, cout=0, single done pulse at original time.
- ena stall: a_in=8'hAA, b_in=8'h55, hold ena=0 for 3 cycles mid-RUN -> state frozen during stall, done at edge 11, sum=8'hFF, cout=0.
- Reset mid-op: start 8'h80+8'h80, assert rst_n low at RUN cycle 4 -> busy, done, sum, cout all 0 immediately and asynchronously; no later done pulse. A subsequent start of 8'h80+8'h80 yields sum=8'h00, cout=1.
- Back-to-back: assert start with 8'h01+8'h02 in the cycle done=1 from the previous op -> new op accepted, done 8 edges later, sum=8'h03, previous sum cleared at acceptance.
